jtkcpu_pshpul: RTL and testbench
================================

# jtkcpu_pshpul

Push/pull sequencer for the JTKCPU core. On a PSHS/PSHU/PULS/PULU (and interrupt stacking/RTI) request, it walks the 8-bit register-select postbyte and drives the register file's stack port one byte at a time. It generates the `psh_sel`, `psh_hilon`, `psh_ussel`, `pshdec` and `pul_en` controls plus the memory read/write strobes. The register file does the data muxing and the pointer arithmetic.

## Interface
Parameters: none.

- `rst`  in  1  reset; asynchronous, active-high
- `clk`  in  1  single core clock
- `cen`  in  1  clock enable; all state advances only when `cen`=1
- `start`  in  1  request strobe, sampled in IDLE only
- `pull`  in  1  0=push, 1=pull; latched at start
- `ussel`  in  1  0=S stack, 1=U stack; latched at start
- `postbyte`  in  8  register mask, latched at start
  - bit0 CC, bit1 A, bit2 B, bit3 DP
  - bit4 X, bit5 Y, bit6 other stack pointer, bit7 PC
- `bus_wait`  in  1  memory not ready; freezes the sequencer
- `psh_sel`  out  8  one-hot select of the register currently transferred
- `psh_hilon`  out  1  1=high byte of a 16-bit register, 0=low byte or 8-bit register
- `psh_ussel`  out  1  latched `ussel`
- `pshdec`  out  1  pre-decrement the stack pointer (push)
- `pul_en`  out  1  load pulled byte into the register and post-increment the stack pointer
- `we`  out  1  memory write strobe (data = register-file `psh_mux`, address = `psh_addr`)
- `rd`  out  1  memory read strobe (address = `psh_addr`)
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, DEC, WR, RD, LD, DONE.
- **IDLE**, on `start`:
  - Latch `mask`=`postbyte`, `pull`, `ussel`.
  - If `mask`=0, go to DONE.
  - Otherwise go to DEC (push) or RD (pull).
- **Push order**: highest set bit first (PC, U/S, Y, X, DP, B, A, CC).
  - 16-bit registers (bits 4-7) go low byte first (`psh_hilon`=0), then high byte.
  - Each byte takes two states:
    - DEC: `pshdec`=1.
    - WR: `we`=1, using the already-decremented pointer.
- **Pull order**: lowest set bit first (CC, A, B, DP, X, Y, U/S, PC).
  - 16-bit registers go high byte first (`psh_hilon`=1), then low byte.
  - Each byte takes two states:
    - RD: `rd`=1.
    - LD: `pul_en`=1, data valid.
- **After WR or LD**:
  - If the current bit is 16-bit and its first byte just finished, toggle `psh_hilon` and repeat on the same bit.
  - Otherwise clear the bit from `mask`.
  - If `mask`≠0, go to DEC (push) or RD (pull); else go to DONE.
- `psh_sel` is the one-hot of the bit being transferred; it is 0 in IDLE and DONE.
- `psh_hilon` on entry to a 16-bit register: 0 for push, 1 for pull. It is 0 for 8-bit registers.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored.
- **`bus_wait`=1**:
  - State and `psh_sel`/`psh_hilon` hold.
  - `we`/`rd` stay asserted.
  - `pshdec` and `pul_en` are forced to 0, so the pointer is never double-stepped.

## Timing
- Reset values: `psh_sel`=0, `psh_hilon`=0, `psh_ussel`=0, `pshdec`=0, `pul_en`=0, `we`=0, `rd`=0, `busy`=0, `done`=0, state IDLE, `mask`=0.
- All outputs are registered or decoded from registered state. There is no combinational path from `start` or `postbyte` to the outputs.
- Latency, counted in `cen` cycles with `start` sampled at cycle 0 and no waits:
  - For N bytes (8-bit register = 1 byte, 16-bit register = 2 bytes), `busy` rises at cycle 1.
  - The first DEC/RD is at cycle 1.
  - `done` is at cycle 2N+1; IDLE is at cycle 2N+2.
- `postbyte`=0: `done` at cycle 1, with no `we`/`rd`/`pshdec`/`pul_en`.
- Each `bus_wait` cycle extends the total by exactly one cycle.
- `cen`=0 freezes everything, including `done` (the pulse lasts one `cen` cycle).
- `rst` mid-operation: immediate return to IDLE with all outputs at reset values. The partial transfer is abandoned.
- `start` in the same cycle as DONE is ignored. A new request is accepted only in IDLE.

## Test plan
- **Push 8-bit pair**: push, `postbyte`=0x06, S stack.
  - Cycle 1: DEC, `psh_sel`=0x04. Cycle 2: WR.
  - Cycle 3: DEC, `psh_sel`=0x02. Cycle 4: WR.
  - Cycle 5: `done`. Exactly 2 `we`, 2 `pshdec`.
- **Push 16-bit**: push, `postbyte`=0x90, U stack (`psh_ussel`=1).
  - `psh_sel` 0x80 with `hilon` 0 then 1, then 0x10 with `hilon` 0 then 1.
  - 4 writes; `done` at cycle 9.
- **Pull all registers**: pull, `postbyte`=0xFF.
  - Order CC, A, B, DP, X(hi, lo), Y(hi, lo), other(hi, lo), PC(hi, lo).
  - 12 `rd`, 12 `pul_en`; `done` at cycle 25.
- **Empty mask**: `postbyte`=0x00.
  - `done` at cycle 1; `busy` high for exactly that cycle; no strobes.
- **Bus wait**: pull 0x01 with `bus_wait` high for 3 cycles during RD.
  - `rd` held 4 cycles; `pul_en` asserts exactly once; `done` at cycle 6.
- **Reset and re-entry**:
  - `rst` asserted at cycle 3 of a 0x06 push: all outputs 0 immediately.
  - A new `start` after reset runs the full sequence from the beginning.
  - A second `start` issued while `busy` has no effect.

Source files
------------

// File: rtl/jtkcpu_pshpul_if.sv
// Request and stack-port bundle for the JTKCPU push/pull sequencer.
// The master side issues requests; the slave side drives the register-file controls.
interface jtkcpu_pshpul_if;
  logic       start;
  logic       pull;
  logic       ussel;
  logic [7:0] postbyte;
  logic       bus_wait;
  logic [7:0] psh_sel;
  logic       psh_hilon;
  logic       psh_ussel;
  logic       pshdec;
  logic       pul_en;
  logic       we;
  logic       rd;
  logic       busy;
  logic       done;

  modport master (
    output start, pull, ussel, postbyte, bus_wait,
    input  psh_sel, psh_hilon, psh_ussel, pshdec, pul_en, we, rd, busy, done
  );

  modport slave (
    input  start, pull, ussel, postbyte, bus_wait,
    output psh_sel, psh_hilon, psh_ussel, pshdec, pul_en, we, rd, busy, done
  );
endinterface

// File: rtl/jtkcpu_pshpul.sv
// Push/pull sequencer: walks the register postbyte one byte at a time and drives
// the register-file stack port controls plus the memory strobes.
module jtkcpu_pshpul (
  input  logic              rst,
  input  logic              clk,
  input  logic              cen,
  jtkcpu_pshpul_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, DEC, WR, RD, LD, DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] mask, mask_nx, mask_left, cur;
  logic       pull_q, pull_nx;
  logic       ussel_q, ussel_nx;
  logic       hilon, hilon_nx;
  logic       xfer, hold;

  // Push walks from the top bit down, pull from the bottom bit up.
  function automatic logic [7:0] pick(input logic [7:0] m, input logic from_low);
    pick = '0;
    if (from_low) begin
      for (int i = 7; i >= 0; i--)
        if (m[i]) begin
          pick    = '0;
          pick[i] = 1'b1;
        end
    end else begin
      for (int i = 0; i < 8; i++)
        if (m[i]) begin
          pick    = '0;
          pick[i] = 1'b1;
        end
    end
  endfunction

  function automatic logic entry_hilon(input logic [7:0] sel, input logic pl);
    entry_hilon = (|(sel & 8'hF0)) & pl;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mask    <= '0;
      pull_q  <= 1'b0;
      ussel_q <= 1'b0;
      hilon   <= 1'b0;
    end else if (cen) begin
      state   <= state_nx;
      mask    <= mask_nx;
      pull_q  <= pull_nx;
      ussel_q <= ussel_nx;
      hilon   <= hilon_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mask_nx   = mask;
    pull_nx   = pull_q;
    ussel_nx  = ussel_q;
    hilon_nx  = hilon;
    xfer      = (state == DEC) || (state == WR) || (state == RD) || (state == LD);
    hold      = bus.bus_wait && xfer;
    cur       = xfer ? pick(mask, pull_q) : 8'h00;
    mask_left = mask & ~cur;
    case (state)
      IDLE: begin
        if (bus.start) begin
          mask_nx  = bus.postbyte;
          pull_nx  = bus.pull;
          ussel_nx = bus.ussel;
          hilon_nx = entry_hilon(pick(bus.postbyte, bus.pull), bus.pull);
          if (bus.postbyte == 8'h00) state_nx = DONE;
          else                       state_nx = bus.pull ? RD : DEC;
        end
      end
      DEC: if (!hold) state_nx = WR;
      RD:  if (!hold) state_nx = LD;
      WR, LD: begin
        if (!hold) begin
          // First byte of a 16-bit register: stay on the bit, swap byte half.
          if ((|(cur & 8'hF0)) && (hilon == pull_q)) begin
            hilon_nx = ~hilon;
            state_nx = pull_q ? RD : DEC;
          end else begin
            mask_nx  = mask_left;
            hilon_nx = entry_hilon(pick(mask_left, pull_q), pull_q);
            if (mask_left == 8'h00) state_nx = DONE;
            else                    state_nx = pull_q ? RD : DEC;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.psh_sel   = cur;
  assign bus.psh_hilon = hilon;
  assign bus.psh_ussel = ussel_q;
  assign bus.pshdec    = (state == DEC) && !bus.bus_wait;
  assign bus.pul_en    = (state == LD) && !bus.bus_wait;
  assign bus.we        = (state == WR);
  assign bus.rd        = (state == RD);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Scoreboard bench for jtkcpu_pshpul: a behavioural model queues the expected
// per-cycle outputs for each request and the checker pops them cycle by cycle.
module tb_jtkcpu_pshpul;

  logic clk, rst, cen;
  jtkcpu_pshpul_if bus();

  jtkcpu_pshpul dut (
    .rst (rst),
    .clk (clk),
    .cen (cen),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp layout: {sel[7:0], hilon, ussel, pshdec, pul_en, we, rd, busy, done}
  typedef struct {
    logic [15:0] exp;
    logic        bw;
    logic        cen;
    logic        st;
  } sb_t;

  sb_t sbQ[$];
  int  checks, errors;
  int  nWe, nRd, nDec, nPul;

  function automatic sb_t mk(input logic [7:0] sel, input logic hl, us, dec, pul,
                             wr, rdd, bsy, dn);
    sb_t e;
    e.exp = {sel, hl, us, dec, pul, wr, rdd, bsy, dn};
    e.bw  = 1'b0;
    e.cen = 1'b1;
    e.st  = 1'b0;
    return e;
  endfunction

  function automatic void modelOp(input logic pl, input logic us, input logic [7:0] pb);
    logic [7:0] sel;
    logic       hl;
    int         i, nb;
    for (int k = 0; k < 8; k++) begin
      i = pl ? k : 7 - k;
      if (pb[i]) begin
        nb  = (i >= 4) ? 2 : 1;
        sel = 8'h00;
        sel[i] = 1'b1;
        for (int b = 0; b < nb; b++) begin
          hl = (i >= 4) ? (pl ? (b == 0) : (b == 1)) : 1'b0;
          if (pl) begin
            sbQ.push_back(mk(sel, hl, us, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
            sbQ.push_back(mk(sel, hl, us, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
          end else begin
            sbQ.push_back(mk(sel, hl, us, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            sbQ.push_back(mk(sel, hl, us, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
          end
        end
      end
    end
    sbQ.push_back(mk(8'h00, 1'b0, us, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    sbQ.push_back(mk(8'h00, 1'b0, us, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endfunction

  function automatic logic [15:0] observed();
    return {bus.psh_sel, bus.psh_hilon, bus.psh_ussel, bus.pshdec, bus.pul_en,
            bus.we, bus.rd, bus.busy, bus.done};
  endfunction

  // Called #1 after a clock edge; leaves the bench #1 after the sampling edge.
  task automatic applyStimulus(input logic pl, input logic us, input logic [7:0] pb);
    nWe = 0; nRd = 0; nDec = 0; nPul = 0;
    modelOp(pl, us, pb);
    bus.pull     = pl;
    bus.ussel    = us;
    bus.postbyte = pb;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int maxN);
    sb_t         e;
    logic [15:0] obs;
    int          n;
    n = 0;
    while (sbQ.size() > 0 && n < maxN) begin
      e = sbQ.pop_front();
      cen          = e.cen;
      bus.bus_wait = e.bw;
      bus.start    = e.st;
      #1;
      obs = observed();
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s step%0d got %h exp %h", tag, n, obs, e.exp);
      end
      if (cen) begin
        nWe  += int'(bus.we);
        nRd  += int'(bus.rd);
        nDec += int'(bus.pshdec);
        nPul += int'(bus.pul_en);
      end
      n++;
      @(posedge clk);
      #1;
    end
    cen          = 1'b1;
    bus.bus_wait = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic checkCount(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  initial begin
    sb_t         e;
    logic [15:0] obs;
    checks = 0; errors = 0;
    nWe = 0; nRd = 0; nDec = 0; nPul = 0;
    rst = 1'b1; cen = 1'b1;
    bus.start = 1'b0; bus.pull = 1'b0; bus.ussel = 1'b0;
    bus.postbyte = 8'h00; bus.bus_wait = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = observed();
    checks++;
    assert (obs === 16'h0000) else begin
      errors++;
      $error("[TB] FAIL reset got %h exp %h", obs, 16'h0000);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] push 0x06 on S");
    applyStimulus(1'b0, 1'b0, 8'h06);
    checkOutput("push06", 100);
    checkCount("push06_we", nWe, 2);
    checkCount("push06_dec", nDec, 2);

    $display("[TB] push 0x90 on U with clock-enable stalls");
    applyStimulus(1'b0, 1'b1, 8'h90);
    e = sbQ[1]; e.cen = 1'b0; sbQ.insert(1, e);
    e = sbQ[9]; e.cen = 1'b0; sbQ.insert(9, e);
    checkOutput("push90", 100);
    checkCount("push90_we", nWe, 4);
    checkCount("push90_dec", nDec, 4);

    $display("[TB] pull 0xFF");
    applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("pullFF", 100);
    checkCount("pullFF_rd", nRd, 12);
    checkCount("pullFF_pul", nPul, 12);

    $display("[TB] empty mask, start during DONE");
    applyStimulus(1'b0, 1'b1, 8'h00);
    bus.postbyte = 8'h06;
    e = sbQ[0]; e.st = 1'b1; sbQ[0] = e;
    checkOutput("empty", 100);
    checkCount("empty_strobes", nWe + nRd + nDec + nPul, 0);

    $display("[TB] pull 0x01 with bus_wait in RD and LD");
    applyStimulus(1'b1, 1'b0, 8'h01);
    e = sbQ[0]; e.bw = 1'b1;
    for (int k = 0; k < 3; k++) sbQ.push_front(e);
    e = sbQ[4]; e.bw = 1'b1; e.exp[4] = 1'b0; sbQ.insert(4, e);
    checkOutput("pullwait", 100);
    checkCount("pullwait_rd", nRd, 4);
    checkCount("pullwait_pul", nPul, 1);

    $display("[TB] push 0x01 with bus_wait in DEC");
    applyStimulus(1'b0, 1'b0, 8'h01);
    e = sbQ[0]; e.bw = 1'b1; e.exp[5] = 1'b0;
    sbQ.push_front(e);
    sbQ.push_front(e);
    checkOutput("pushwait", 100);
    checkCount("pushwait_dec", nDec, 1);
    checkCount("pushwait_we", nWe, 1);

    $display("[TB] reset mid-push, then re-entry");
    applyStimulus(1'b0, 1'b1, 8'h06);
    checkOutput("rstpre", 2);
    rst = 1'b1;
    #1;
    obs = observed();
    checks++;
    assert (obs === 16'h0000) else begin
      errors++;
      $error("[TB] FAIL midreset got %h exp %h", obs, 16'h0000);
    end
    sbQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 8'h06);
    bus.pull = 1'b1;
    bus.postbyte = 8'hFF;
    e = sbQ[1]; e.st = 1'b1; sbQ[1] = e;
    checkOutput("reentry", 100);
    checkCount("reentry_we", nWe, 2);
    checkCount("reentry_rd", nRd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
